// File: rtl/mano_ctrl_p.sv
// Control unit for the Basic Computer datapath: fetch/decode/indirect/execute
// sequencing, prioritised vectored interrupts, I/O instructions and halt/restart.
module mano_ctrl_p #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int IRQ_N    = 1,
    parameter int VEC_BASE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] IR,
    input  logic              ac_zero,
    input  logic              ac_msb,
    input  logic              ac_lsb,
    input  logic              e,
    input  logic              co,
    input  logic              dr_zero,
    input  logic              fgi,
    input  logic              fgo,
    input  logic [IRQ_N-1:0]  irq_req,
    input  logic              run,
    output logic [2:0]        bus_sel,
    output logic              write_ar,
    output logic              write_pc,
    output logic              write_dr,
    output logic              write_ac,
    output logic              write_ir,
    output logic              write_tr,
    output logic              write_outr,
    output logic              increment_ar,
    output logic              increment_pc,
    output logic              increment_dr,
    output logic              increment_ac,
    output logic              reset_ac,
    output logic              write_vec_ar,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              memory_read,
    output logic              memory_write,
    output logic [2:0]        alu_op,
    output logic              clear_e,
    output logic              comp_e,
    output logic              set_e,
    output logic              clear_fgi,
    output logic              clear_fgo,
    output logic [IRQ_N-1:0]  irq_ack,
    output logic              ien,
    output logic              halted,
    output logic [2:0]        sc
);

    localparam int KW = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
    localparam logic [ADDR_W-1:0] VEC_BASE_A = ADDR_W'(VEC_BASE);

    typedef enum logic [2:0] {
        OP_AND, OP_ADD, OP_LDA, OP_STA, OP_BUN, OP_BSA, OP_ISZ, OP_REG
    } opcode_e;

    typedef enum logic [2:0] {
        BUS_NONE, BUS_AR, BUS_PC, BUS_DR, BUS_AC, BUS_IR, BUS_TR, BUS_MEM
    } bus_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_AND, ALU_PASS, ALU_CMA, ALU_CIR, ALU_CIL, ALU_INPR
    } alu_e;

    logic [2:0]    sc_q;
    logic          r_q, ien_q, halted_q, i_q;
    opcode_e       op_q;
    logic [KW-1:0] k_q, k_low, k_sel;
    logic [11:0]   rr_hot;
    logic [5:0]    io_hot;
    logic          last, do_hlt, do_ion, do_iof, take_irq;
    bus_e          bus_d;
    alu_e          alu_d;

    assign take_irq = ien_q && (|irq_req);

    // Lowest-numbered request has priority; highest IR bit wins in the decodes.
    always_comb begin
        k_low = '0;
        for (int j = IRQ_N - 1; j >= 0; j--)
            if (irq_req[j]) k_low = KW'(j);
    end

    always_comb begin
        rr_hot = '0;
        io_hot = '0;
        for (int j = 0; j < 12; j++)
            if (IR[ADDR_W-12+j]) rr_hot = 12'(1) << j;
        for (int j = 0; j < 6; j++)
            if (IR[ADDR_W-6+j]) io_hot = 6'(1) << j;
    end

    assign k_sel    = (r_q && sc_q == 3'd0) ? k_low : k_q;
    assign vec_addr = VEC_BASE_A + (ADDR_W'(k_sel) << 1);

    assign bus_sel = bus_d;
    assign alu_op  = alu_d;
    assign ien     = ien_q;
    assign halted  = halted_q;
    assign sc      = sc_q;

    // Strobes are gated by reset_n so they drop the instant reset asserts.
    always_comb begin
        bus_d = BUS_NONE;   alu_d = ALU_ADD;
        write_ar = 1'b0;    write_pc = 1'b0;    write_dr = 1'b0;   write_ac = 1'b0;
        write_ir = 1'b0;    write_tr = 1'b0;    write_outr = 1'b0;
        increment_ar = 1'b0; increment_pc = 1'b0; increment_dr = 1'b0;
        increment_ac = 1'b0; reset_ac = 1'b0;   write_vec_ar = 1'b0;
        memory_read = 1'b0; memory_write = 1'b0;
        clear_e = 1'b0; comp_e = 1'b0; set_e = 1'b0; clear_fgi = 1'b0; clear_fgo = 1'b0;
        irq_ack = '0;
        last = 1'b0; do_hlt = 1'b0; do_ion = 1'b0; do_iof = 1'b0;
        if (reset_n && !halted_q) begin
            if (r_q) begin
                case (sc_q)
                    3'd0:    begin write_vec_ar = 1'b1; bus_d = BUS_PC; write_tr = 1'b1; end
                    3'd1:    begin bus_d = BUS_TR; memory_write = 1'b1; increment_ar = 1'b1; end
                    default: begin bus_d = BUS_AR; write_pc = 1'b1; irq_ack = IRQ_N'(1) << k_q; end
                endcase
            end else begin
                case (sc_q)
                    3'd0: begin bus_d = BUS_PC; write_ar = 1'b1; end
                    3'd1: begin memory_read = 1'b1; bus_d = BUS_MEM; write_ir = 1'b1; increment_pc = 1'b1; end
                    3'd2: begin bus_d = BUS_IR; write_ar = 1'b1; end
                    3'd3: begin
                        if (op_q == OP_REG) begin
                            last = 1'b1;
                            if (!i_q) begin
                                case (rr_hot)
                                    12'h800: reset_ac = 1'b1;
                                    12'h400: clear_e = 1'b1;
                                    12'h200: begin alu_d = ALU_CMA; write_ac = 1'b1; end
                                    12'h100: comp_e = 1'b1;
                                    12'h080: begin alu_d = ALU_CIR; write_ac = 1'b1; set_e = ac_lsb; clear_e = !ac_lsb; end
                                    12'h040: begin alu_d = ALU_CIL; write_ac = 1'b1; set_e = ac_msb; clear_e = !ac_msb; end
                                    12'h020: increment_ac = 1'b1;
                                    12'h010: increment_pc = !ac_msb && !ac_zero;
                                    12'h008: increment_pc = ac_msb;
                                    12'h004: increment_pc = ac_zero;
                                    12'h002: increment_pc = !e;
                                    12'h001: do_hlt = 1'b1;
                                    default: ;
                                endcase
                            end else begin
                                case (io_hot)
                                    6'h20:   begin alu_d = ALU_INPR; write_ac = 1'b1; clear_fgi = 1'b1; end
                                    6'h10:   begin bus_d = BUS_AC; write_outr = 1'b1; clear_fgo = 1'b1; end
                                    6'h08:   increment_pc = fgi;
                                    6'h04:   increment_pc = fgo;
                                    6'h02:   do_ion = 1'b1;
                                    6'h01:   do_iof = 1'b1;
                                    default: ;
                                endcase
                            end
                        end else if (i_q) begin
                            memory_read = 1'b1; bus_d = BUS_MEM; write_ar = 1'b1;
                        end
                    end
                    3'd4: begin
                        case (op_q)
                            OP_AND, OP_ADD, OP_LDA, OP_ISZ:
                                begin memory_read = 1'b1; bus_d = BUS_MEM; write_dr = 1'b1; end
                            OP_STA:  begin bus_d = BUS_AC; memory_write = 1'b1; last = 1'b1; end
                            OP_BUN:  begin bus_d = BUS_AR; write_pc = 1'b1; last = 1'b1; end
                            OP_BSA:  begin bus_d = BUS_PC; memory_write = 1'b1; increment_ar = 1'b1; end
                            default: last = 1'b1;
                        endcase
                    end
                    3'd5: begin
                        case (op_q)
                            OP_AND:  begin alu_d = ALU_AND; write_ac = 1'b1; last = 1'b1; end
                            OP_ADD:  begin alu_d = ALU_ADD; write_ac = 1'b1; set_e = co; clear_e = !co; last = 1'b1; end
                            OP_LDA:  begin alu_d = ALU_PASS; write_ac = 1'b1; last = 1'b1; end
                            OP_BSA:  begin bus_d = BUS_AR; write_pc = 1'b1; last = 1'b1; end
                            OP_ISZ:  increment_dr = 1'b1;
                            default: last = 1'b1;
                        endcase
                    end
                    default: begin
                        last = 1'b1;
                        if (sc_q == 3'd6 && op_q == OP_ISZ) begin
                            bus_d = BUS_DR; memory_write = 1'b1; increment_pc = dr_zero;
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every branch sees pre-edge values (e.g. ien for ION).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc_q     <= 3'd0;
            r_q      <= 1'b0;
            ien_q    <= 1'b0;
            halted_q <= 1'b0;
            i_q      <= 1'b0;
            op_q     <= OP_AND;
            k_q      <= '0;
        end else if (halted_q) begin
            if (take_irq) begin
                halted_q <= 1'b0;
                r_q      <= 1'b1;
            end else if (run) begin
                halted_q <= 1'b0;
            end
        end else if (r_q) begin
            case (sc_q)
                3'd0:    begin k_q <= k_low; sc_q <= 3'd1; end
                3'd1:    sc_q <= 3'd2;
                default: begin ien_q <= 1'b0; r_q <= 1'b0; sc_q <= 3'd0; end
            endcase
        end else if (last) begin
            sc_q <= 3'd0;
            if (take_irq)    r_q      <= 1'b1;
            else if (do_hlt) halted_q <= 1'b1;
            if (do_ion)      ien_q    <= 1'b1;
            else if (do_iof) ien_q    <= 1'b0;
        end else begin
            sc_q <= sc_q + 3'd1;
            if (sc_q == 3'd2) begin
                op_q <= opcode_e'(IR[DATA_W-2 -: 3]);
                i_q  <= IR[DATA_W-1];
            end
        end
    end

endmodule
